div_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one unsigned fixed-point `divider` instance between `NREQ` requesters. It latches the winning requester's operands and pulses the divider's `start`. It then waits for the divider's `valid`, or for a watchdog timeout, and returns the quotient and status flags to the granted requester with a one-cycle response pulse. It sits between the requester logic and the `divider` top in the datapath.

---
 rtl/div_arb_pkg.sv | 27 ++
 rtl/rr_arbiter.sv | 35 +++
 rtl/div_arbiter.sv | 131 +++++++++++++
 tb/tb_div_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_arb_pkg.sv
// Shared types for the divider arbiter: FSM encoding, default width and
// the response record returned to the granted requester.
package div_arb_pkg;

    localparam int DIV_ARB_W = 10;

    // Fixed encodings so the state register matches older netlists
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = S_IDLE,
        ISSUE = S_ISSUE,
        WAIT  = S_WAIT,
        RESP  = S_RESP
    } div_arb_state_t;

    typedef struct packed {
        logic [DIV_ARB_W-1:0] q;
        logic                 dvz;
        logic                 ovf;
        logic                 tmo;
    } div_arb_rsp_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr,
// wrapping modulo NREQ. Returns one-hot grant, its index and a hit flag.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   idx,
    output logic            any
);

    // Scan NREQ positions starting at ptr; the first hit wins
    always_comb begin
        int            k;
        logic [IW-1:0] kk;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        k     = 0;
        kk    = '0;
        for (int i = 0; i < NREQ; i++) begin
            k = int'(ptr) + i;
            if (k >= NREQ) k = k - NREQ;
            kk = IW'(k);
            if (!any && req[kk]) begin
                any = 1'b1;
                idx = kk;
            end
        end
        if (any) grant[idx] = 1'b1;
    end

endmodule

// File: rtl/div_arbiter.sv
// Shares one divider between NREQ requesters: round-robin grant, operand
// latch, start pulse, wait for valid or watchdog abort, one-cycle response.
module div_arbiter
    import div_arb_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int W       = DIV_ARB_W,
    parameter int TIMEOUT = 31
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ-1:0][W-1:0] a_req,
    input  logic [NREQ-1:0][W-1:0] b_req,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       rsp_valid,
    output logic [W-1:0]          rsp_q,
    output logic                  rsp_dvz,
    output logic                  rsp_ovf,
    output logic                  rsp_tmo,
    output logic [W-1:0]          div_a,
    output logic [W-1:0]          div_b,
    output logic                  div_start,
    output logic                  div_sclr,
    input  logic [W-1:0]          div_q,
    input  logic                  div_dvz,
    input  logic                  div_ovf,
    input  logic                  div_busy,
    input  logic                  div_valid
);

    localparam int IW  = $clog2(NREQ);
    localparam int WDW = $clog2(TIMEOUT + 1);
    // wdog counts completed WAIT cycles; WAIT lasts at most TIMEOUT cycles,
    // and the clear pulse is raised in the last of them so RESP follows it.
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);
    localparam logic [WDW-1:0] WD_PRE  = WDW'(TIMEOUT - 2);
    localparam logic [IW-1:0]  LAST_IX = IW'(NREQ - 1);

    if (W != DIV_ARB_W) begin : g_w_chk
        $error("div_arbiter: W must equal DIV_ARB_W");
    end
    if (TIMEOUT < 2) begin : g_to_chk
        $error("div_arbiter: TIMEOUT must be at least 2");
    end

    div_arb_state_t  state;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   own;
    logic [WDW-1:0]  wdog;
    div_arb_rsp_t    rsp;

    logic [NREQ-1:0] pick_oh;
    logic [IW-1:0]   pick_idx;
    logic            pick_any;

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr (
        .req   (req),
        .ptr   (ptr),
        .grant (pick_oh),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    assign rsp_q   = rsp.q;
    assign rsp_dvz = rsp.dvz;
    assign rsp_ovf = rsp.ovf;
    assign rsp_tmo = rsp.tmo;

    // Sequencer: grant/latch, start, wait with watchdog, respond, rotate pointer
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            ptr       <= '0;
            own       <= '0;
            wdog      <= '0;
            gnt       <= '0;
            rsp_valid <= '0;
            rsp       <= '0;
            div_a     <= '0;
            div_b     <= '0;
            div_start <= 1'b0;
            div_sclr  <= 1'b1;
        end else begin
            div_start <= 1'b0;
            div_sclr  <= 1'b0;
            rsp_valid <= '0;
            case (state)
                IDLE: begin
                    if (pick_any && !div_busy) begin
                        own       <= pick_idx;
                        gnt       <= pick_oh;
                        div_a     <= a_req[pick_idx];
                        div_b     <= b_req[pick_idx];
                        div_start <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    wdog  <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    // A result arriving in the final WAIT cycle still wins
                    if (div_valid) begin
                        rsp       <= '{q: div_q, dvz: div_dvz, ovf: div_ovf, tmo: 1'b0};
                        rsp_valid <= gnt;
                        state     <= RESP;
                    end else if (wdog == WD_LAST) begin
                        rsp       <= '{q: '0, dvz: 1'b0, ovf: 1'b0, tmo: 1'b1};
                        rsp_valid <= gnt;
                        state     <= RESP;
                    end else begin
                        wdog <= wdog + 1'b1;
                        if (wdog == WD_PRE) div_sclr <= 1'b1;
                    end
                end
                RESP: begin
                    ptr   <= (own == LAST_IX) ? '0 : own + 1'b1;
                    gnt   <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_arbiter.sv
// Bench for div_arbiter: behavioural divider model, directed stimulus that
// queues hand-computed responses, and a monitor that checks every pulse.
module tb_div_arbiter;

    localparam int NREQ    = 4;
    localparam int W       = 10;
    localparam int TIMEOUT = 31;
    localparam int LAT     = 3;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NREQ-1:0]        req;
    logic [NREQ-1:0][W-1:0] a_req;
    logic [NREQ-1:0][W-1:0] b_req;
    logic [NREQ-1:0]        gnt;
    logic [NREQ-1:0]        rsp_valid;
    logic [W-1:0]           rsp_q;
    logic                   rsp_dvz, rsp_ovf, rsp_tmo;
    logic [W-1:0]           div_a, div_b;
    logic                   div_start, div_sclr;
    logic [W-1:0]           div_q;
    logic                   div_dvz, div_ovf, div_busy, div_valid;

    // model controls
    logic stall;
    logic force_busy;
    logic m_busy;
    int   cnt;
    logic [W-1:0] m_q;
    logic m_dvz, m_ovf;
    logic [W+3:0] full;

    typedef struct {
        int         idx;
        logic [W-1:0] q;
        bit         dvz;
        bit         ovf;
        bit         tmo;
    } exp_t;
    exp_t exp_q[$];

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int issue_cyc = 0;
    bit rst_seen = 1'b0;
    logic prev_valid = 1'b0;
    logic prev_sclr = 1'b0;

    always #5 clk = ~clk;

    assign div_busy = force_busy | m_busy;

    div_arbiter #(.NREQ(NREQ), .W(W), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .a_req     (a_req),
        .b_req     (b_req),
        .gnt       (gnt),
        .rsp_valid (rsp_valid),
        .rsp_q     (rsp_q),
        .rsp_dvz   (rsp_dvz),
        .rsp_ovf   (rsp_ovf),
        .rsp_tmo   (rsp_tmo),
        .div_a     (div_a),
        .div_b     (div_b),
        .div_start (div_start),
        .div_sclr  (div_sclr),
        .div_q     (div_q),
        .div_dvz   (div_dvz),
        .div_ovf   (div_ovf),
        .div_busy  (div_busy),
        .div_valid (div_valid)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Divider model: Q6.4 result of a/b, LAT cycles after start, optional stall
    always @(posedge clk) begin
        #1;
        div_valid = 1'b0;
        if (!rst || div_sclr) begin
            cnt = 0;
        end else begin
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    div_valid = 1'b1;
                    div_q     = m_q;
                    div_dvz   = m_dvz;
                    div_ovf   = m_ovf;
                end
            end
            if (div_start && !stall) begin
                m_dvz = 1'b0;
                m_ovf = 1'b0;
                if (div_b == '0) begin
                    m_dvz = 1'b1;
                    m_q   = '1;
                end else begin
                    full = {div_a, 4'b0000} / {4'b0000, div_b};
                    if (|full[W+3:W]) begin
                        m_ovf = 1'b1;
                        m_q   = '1;
                    end else begin
                        m_q = full[W-1:0];
                    end
                end
                cnt = LAT;
            end
        end
        m_busy = (cnt > 0);
    end

    // Cycle count and the reset level the DUT actually sampled
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= rst;
    end

    // Monitor: check clear timing and every response pulse against the queue
    always @(negedge clk) begin
        exp_t e;
        if (div_start) issue_cyc = cyc;
        if (rst_seen && div_sclr) check("sclr_delay", cyc - issue_cyc, TIMEOUT);
        if (rsp_valid != '0) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", {28'd0, rsp_valid}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("rsp_owner", {28'd0, rsp_valid}, 32'd1 << e.idx);
                check("rsp_vs_gnt", {28'd0, rsp_valid}, {28'd0, gnt});
                check("rsp_q", {22'd0, rsp_q}, {22'd0, e.q});
                check("rsp_dvz", {31'd0, rsp_dvz}, {31'd0, e.dvz});
                check("rsp_ovf", {31'd0, rsp_ovf}, {31'd0, e.ovf});
                check("rsp_tmo", {31'd0, rsp_tmo}, {31'd0, e.tmo});
                if (e.tmo) begin
                    check("tmo_delay", cyc - issue_cyc, TIMEOUT + 1);
                    check("tmo_sclr_prev", {31'd0, prev_sclr}, 32'd1);
                end else begin
                    check("rsp_after_valid", {31'd0, prev_valid}, 32'd1);
                end
            end
        end
        prev_valid = div_valid;
        prev_sclr  = div_sclr;
    end

    task automatic push_exp(input int idx, input int q, input bit dvz, input bit ovf, input bit tmo);
        exp_t e;
        e.idx = idx;
        e.q   = W'(q);
        e.dvz = dvz;
        e.ovf = ovf;
        e.tmo = tmo;
        exp_q.push_back(e);
    endtask

    task automatic wait_rsp(input string name, input int max_cyc);
        bit seen = 1'b0;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            @(negedge clk);
            if (|rsp_valid) seen = 1'b1;
        end
        check(name, {31'd0, seen}, 32'd1);
    endtask

    task automatic run_one(input int idx, input int a, input int b,
                           input int q, input bit dvz, input bit ovf, input bit tmo);
        a_req[idx] = W'(a);
        b_req[idx] = W'(b);
        push_exp(idx, q, dvz, ovf, tmo);
        req[idx] = 1'b1;
        wait_rsp("rsp_arrives", 100);
        req = '0;
        @(negedge clk);
        check("rsp_one_cycle", {28'd0, rsp_valid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        bit got;
        rst        = 1'b0;
        req        = '0;
        a_req      = '0;
        b_req      = '0;
        stall      = 1'b0;
        force_busy = 1'b0;
        m_busy     = 1'b0;
        div_valid  = 1'b0;
        div_q      = '0;
        div_dvz    = 1'b0;
        div_ovf    = 1'b0;
        m_q        = '0;
        m_dvz      = 1'b0;
        m_ovf      = 1'b0;
        full       = '0;
        repeat (3) @(negedge clk);

        // reset values
        check("rst_gnt", {28'd0, gnt}, 0);
        check("rst_rsp_valid", {28'd0, rsp_valid}, 0);
        check("rst_start", {31'd0, div_start}, 0);
        check("rst_sclr", {31'd0, div_sclr}, 1);
        check("rst_div_a", {22'd0, div_a}, 0);
        check("rst_div_b", {22'd0, div_b}, 0);
        check("rst_rsp_q", {22'd0, rsp_q}, 0);
        check("rst_flags", {29'd0, rsp_dvz, rsp_ovf, rsp_tmo}, 0);
        rst = 1'b1;
        @(negedge clk);
        check("sclr_release", {31'd0, div_sclr}, 0);

        // requester 2 alone: grant and start one cycle after the request
        a_req[2] = 10'd200;
        b_req[2] = 10'd100;
        push_exp(2, 32, 0, 0, 0);
        req = 4'b0100;
        @(negedge clk);
        check("t1_gnt", {28'd0, gnt}, 32'b0100);
        check("t1_start", {31'd0, div_start}, 1);
        check("t1_div_a", {22'd0, div_a}, 200);
        check("t1_div_b", {22'd0, div_b}, 100);
        @(negedge clk);
        check("t1_start_pulse", {31'd0, div_start}, 0);
        wait_rsp("t1_rsp", 40);
        req = '0;
        @(negedge clk);
        check("t1_gnt_clear", {28'd0, gnt}, 0);

        // divide by zero, then overflow
        run_one(0, 50, 0, 10'h3FF, 1, 0, 0);
        run_one(1, 1000, 1, 10'h3FF, 0, 1, 0);

        // stalled divider: watchdog abort, then a normal operation
        stall = 1'b1;
        run_one(1, 5, 1, 0, 0, 0, 1);
        stall = 1'b0;
        run_one(3, 100, 7, 228, 0, 0, 0);

        // divider busy in IDLE holds off the grant
        force_busy = 1'b1;
        a_req[2]   = 10'd30;
        b_req[2]   = 10'd3;
        push_exp(2, 160, 0, 0, 0);
        req = 4'b0100;
        repeat (5) @(negedge clk);
        check("busy_no_gnt", {28'd0, gnt}, 0);
        check("busy_no_start", {31'd0, div_start}, 0);
        force_busy = 1'b0;
        @(negedge clk);
        check("busy_release_gnt", {28'd0, gnt}, 32'b0100);
        wait_rsp("busy_rsp", 40);
        req = '0;
        @(negedge clk);

        // reset during WAIT: no response, reset values, pointer back to 0
        a_req[1] = 10'd10;
        b_req[1] = 10'd2;
        req = 4'b0010;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (gnt != '0) got = 1'b1;
        end
        check("midrst_gnt", {28'd0, gnt}, 32'b0010);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_gnt0", {28'd0, gnt}, 0);
        check("midrst_rsp0", {28'd0, rsp_valid}, 0);
        check("midrst_start0", {31'd0, div_start}, 0);
        check("midrst_sclr1", {31'd0, div_sclr}, 1);
        check("midrst_div_a0", {22'd0, div_a}, 0);
        check("midrst_div_b0", {22'd0, div_b}, 0);
        @(negedge clk);
        a_req[3] = 10'd999;
        b_req[3] = 10'd1;
        push_exp(1, 80, 0, 0, 0);
        req = 4'b1010;
        rst = 1'b1;
        @(negedge clk);
        check("ptr_after_rst_gnt", {28'd0, gnt}, 32'b0010);
        wait_rsp("ptr_after_rst_rsp", 40);
        req = '0;
        @(negedge clk);

        // all requesters held from reset: order 0,1,2,3,0
        rst = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            a_req[i] = W'((i + 1) * 100);
            b_req[i] = W'(i + 3);
        end
        push_exp(0, 533, 0, 0, 0);
        push_exp(1, 800, 0, 0, 0);
        push_exp(2, 960, 0, 0, 0);
        push_exp(3, 10'h3FF, 0, 1, 0);
        push_exp(0, 533, 0, 0, 0);
        req = 4'b1111;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 5; k++) wait_rsp("fair_rsp", 40);
        req = '0;

        repeat (6) @(negedge clk);
        check("exp_queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
